// File: rtl/pattern_timing_generator.sv
// rtl/pattern_timing_generator.sv - raster timing and test pattern generator
//
// Purpose: free-running video timing generator producing DE, hsync and vsync
// together with one of four test patterns. These are colour bars, grey ramp,
// checkerboard and solid colour. Every output is registered. The outputs
// after a clock edge describe the counter position held before that edge.
//
// Ports:
//   pixelClock      in   1   pixel clock, all state changes on its rising edge
//   resetN          in   1   asynchronous active-low reset
//   patternSelect   in   2   0 bars, 1 grey ramp, 2 checkerboard, 3 solid
//   solidColour     in  24   {R,G,B} used by the solid pattern
//   DE              out  1   display enable, high in the active region
//   hsync, vsync    out  1   sync outputs, active level SYNC_POL
//   redComponent    out  8   channel 2 pixel component
//   greenComponent  out  8   channel 1 pixel component
//   blueComponent   out  8   channel 0 pixel component
//   xCoord, yCoord  out 12   raw counter position of the presented pixel
//   frameStart      out  1   pulse presented together with pixel (0,0)

module pattern_timing_generator #(
   parameter int H_ACTIVE = 640,
   parameter int H_FRONT  = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BACK   = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FRONT  = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BACK   = 33,
   parameter int SYNC_POL = 0
) (
   input  logic        pixelClock,
   input  logic        resetN,
   input  logic [1:0]  patternSelect,
   input  logic [23:0] solidColour,
   output logic        DE,
   output logic        hsync,
   output logic        vsync,
   output logic [7:0]  redComponent,
   output logic [7:0]  greenComponent,
   output logic [7:0]  blueComponent,
   output logic [11:0] xCoord,
   output logic [11:0] yCoord,
   output logic        frameStart
);

   localparam logic [11:0] H_ACT_END   = 12'(H_ACTIVE);
   localparam logic [11:0] H_SYNC_BEG  = 12'(H_ACTIVE + H_FRONT);
   localparam logic [11:0] H_SYNC_END  = 12'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [11:0] H_LAST      = 12'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
   localparam logic [11:0] V_ACT_END   = 12'(V_ACTIVE);
   localparam logic [11:0] V_SYNC_BEG  = 12'(V_ACTIVE + V_FRONT);
   localparam logic [11:0] V_SYNC_END  = 12'(V_ACTIVE + V_FRONT + V_SYNC);
   localparam logic [11:0] V_LAST      = 12'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
   localparam logic [11:0] BAR_LAST    = 12'(H_ACTIVE / 8 - 1);
   localparam logic        SYNC_ACT    = (SYNC_POL != 0);

   localparam logic [1:0]  PAT_BARS    = 2'd0;
   localparam logic [1:0]  PAT_RAMP    = 2'd1;
   localparam logic [1:0]  PAT_CHECKER = 2'd2;

   logic [11:0] hCount;
   logic [11:0] vCount;
   logic [7:0]  frameCounter;
   logic [1:0]  latchedPattern;
   logic [23:0] latchedColour;
   logic [11:0] barDown;
   logic [2:0]  barIdx;

   logic        active;
   logic        hsActive;
   logic        vsActive;
   logic        atOrigin;
   logic        frameEnd;
   logic [1:0]  effPattern;
   logic [23:0] effColour;
   logic [7:0]  pixR;
   logic [7:0]  pixG;
   logic [7:0]  pixB;

   always_comb begin
      active   = (hCount < H_ACT_END) && (vCount < V_ACT_END);
      hsActive = (hCount >= H_SYNC_BEG) && (hCount < H_SYNC_END);
      vsActive = (vCount >= V_SYNC_BEG) && (vCount < V_SYNC_END);
      atOrigin = (hCount == 12'd0) && (vCount == 12'd0);
      frameEnd = (hCount == H_LAST) && (vCount == V_LAST);
      // The pixel at (0,0) already belongs to the new frame, so it uses the
      // live inputs that are being latched on this same edge.
      effPattern = atOrigin ? patternSelect : latchedPattern;
      effColour  = atOrigin ? solidColour   : latchedColour;
   end

   always_comb begin
      pixR = 8'h00;
      pixG = 8'h00;
      pixB = 8'h00;
      if (active) begin
         case (effPattern)
            PAT_BARS: begin
               // Bar order white,yellow,cyan,green,magenta,red,blue,black
               // reduces to inverted index bits: R=~i[1], G=~i[2], B=~i[0].
               pixR = {8{~barIdx[1]}};
               pixG = {8{~barIdx[2]}};
               pixB = {8{~barIdx[0]}};
            end
            PAT_RAMP: begin
               pixR = hCount[7:0];
               pixG = hCount[7:0];
               pixB = hCount[7:0];
            end
            PAT_CHECKER: begin
               pixR = {8{hCount[5] ^ vCount[5] ^ frameCounter[6]}};
               pixG = {8{hCount[5] ^ vCount[5] ^ frameCounter[6]}};
               pixB = {8{hCount[5] ^ vCount[5] ^ frameCounter[6]}};
            end
            default: begin
               pixR = effColour[23:16];
               pixG = effColour[15:8];
               pixB = effColour[7:0];
            end
         endcase
      end
   end

   always_ff @(posedge pixelClock or negedge resetN) begin
      if (!resetN) begin
         hCount         <= 12'd0;
         vCount         <= 12'd0;
         frameCounter   <= 8'd0;
         latchedPattern <= PAT_BARS;
         latchedColour  <= 24'd0;
         barDown        <= BAR_LAST;
         barIdx         <= 3'd0;
         DE             <= 1'b0;
         hsync          <= ~SYNC_ACT;
         vsync          <= ~SYNC_ACT;
         redComponent   <= 8'd0;
         greenComponent <= 8'd0;
         blueComponent  <= 8'd0;
         xCoord         <= 12'd0;
         yCoord         <= 12'd0;
         frameStart     <= 1'b0;
      end else begin
         if (hCount == H_LAST) begin
            hCount <= 12'd0;
            vCount <= (vCount == V_LAST) ? 12'd0 : vCount + 12'd1;
         end else begin
            hCount <= hCount + 12'd1;
         end

         // Advancing on the wrap into (0,0) keeps one value across a whole frame.
         if (frameEnd) begin
            frameCounter <= frameCounter + 8'd1;
         end

         if (atOrigin) begin
            latchedPattern <= patternSelect;
            latchedColour  <= solidColour;
         end

         // Bar index tracks hCount through a per-bar down-counter and restarts
         // on every line, so the bar index never needs hCount divided by the bar width.
         if (hCount == H_LAST) begin
            barDown <= BAR_LAST;
            barIdx  <= 3'd0;
         end else if (hCount < H_ACT_END) begin
            if (barDown == 12'd0) begin
               barDown <= BAR_LAST;
               barIdx  <= barIdx + 3'd1;
            end else begin
               barDown <= barDown - 12'd1;
            end
         end

         DE             <= active;
         hsync          <= hsActive ? SYNC_ACT : ~SYNC_ACT;
         vsync          <= vsActive ? SYNC_ACT : ~SYNC_ACT;
         redComponent   <= pixR;
         greenComponent <= pixG;
         blueComponent  <= pixB;
         xCoord         <= hCount;
         yCoord         <= vCount;
         frameStart     <= atOrigin;
      end
   end

endmodule

// File: tb/tb_pattern_timing_generator.sv
// tb/tb_pattern_timing_generator.sv - self-checking bench for pattern_timing_generator

module tb_pattern_timing_generator;

   localparam int HT = 56;
   localparam int VT = 12;
   localparam int FR = HT * VT;
   localparam int FRB = 60;

   logic        clk;
   logic        resetN;
   logic [1:0]  patternSelect;
   logic [23:0] solidColour;
   logic        de, hs, vs, fs;
   logic [7:0]  rC, gC, bC;
   logic [11:0] xC, yC;

   logic [1:0]  patB;
   logic [23:0] solidB;
   logic        deB, hsB, vsB, fsB;
   logic [7:0]  rB, gB, bB;
   logic [11:0] xB, yB;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   pattern_timing_generator #(
      .H_ACTIVE(48), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
      .V_ACTIVE(8), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_POL(0)
   ) dutA (
      .pixelClock(clk), .resetN(resetN), .patternSelect(patternSelect),
      .solidColour(solidColour), .DE(de), .hsync(hs), .vsync(vs),
      .redComponent(rC), .greenComponent(gC), .blueComponent(bC),
      .xCoord(xC), .yCoord(yC), .frameStart(fs)
   );

   pattern_timing_generator #(
      .H_ACTIVE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
      .V_ACTIVE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .SYNC_POL(1)
   ) dutB (
      .pixelClock(clk), .resetN(resetN), .patternSelect(patB),
      .solidColour(solidB), .DE(deB), .hsync(hsB), .vsync(vsB),
      .redComponent(rB), .greenComponent(gB), .blueComponent(bB),
      .xCoord(xB), .yCoord(yB), .frameStart(fsB)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      int          frame;
      int          h;
      int          v;
      logic [1:0]  pat;
      logic [23:0] solid;
      logic [23:0] rgb;
      logic        fs;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input int f, input int h, input int v, input logic [1:0] p,
                      input logic [23:0] s, input logic [23:0] rgb, input logic fsE);
      vec_t e;
      e.frame = f; e.h = h; e.v = v; e.pat = p; e.solid = s; e.rgb = rgb; e.fs = fsE;
      vecs.push_back(e);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   function automatic logic expDe(input int h, input int v);
      return (h < 48) && (v < 8);
   endfunction
   function automatic logic expHs(input int h);
      return (h >= 50 && h < 54) ? 1'b0 : 1'b1;
   endfunction
   function automatic logic expVs(input int v);
      return (v >= 9 && v < 11) ? 1'b0 : 1'b1;
   endfunction

   initial begin
      int target;
      int p;
      int f;
      int deCnt, hsCnt, vsCnt, fsCnt;

      resetN = 1'b0;
      patternSelect = 2'd0;
      solidColour = 24'h0;
      patB = 2'd2;
      solidB = 24'h0;

      // frame 0: bars
      add(0, 0, 0, 2'd0, 24'h0, 24'hFFFFFF, 1'b1);
      add(0, 1, 0, 2'd0, 24'h0, 24'hFFFFFF, 1'b0);
      add(0, 5, 0, 2'd0, 24'h0, 24'hFFFFFF, 1'b0);
      add(0, 6, 0, 2'd0, 24'h0, 24'hFFFF00, 1'b0);
      add(0, 12, 0, 2'd0, 24'h0, 24'h00FFFF, 1'b0);
      add(0, 18, 0, 2'd0, 24'h0, 24'h00FF00, 1'b0);
      add(0, 24, 0, 2'd0, 24'h0, 24'hFF00FF, 1'b0);
      add(0, 30, 0, 2'd0, 24'h0, 24'hFF0000, 1'b0);
      add(0, 36, 0, 2'd0, 24'h0, 24'h0000FF, 1'b0);
      add(0, 42, 0, 2'd0, 24'h0, 24'h000000, 1'b0);
      add(0, 47, 0, 2'd0, 24'h0, 24'h000000, 1'b0);
      add(0, 48, 0, 2'd0, 24'h0, 24'h000000, 1'b0);
      add(0, 50, 0, 2'd0, 24'h0, 24'h000000, 1'b0);
      add(0, 53, 0, 2'd0, 24'h0, 24'h000000, 1'b0);
      add(0, 54, 0, 2'd0, 24'h0, 24'h000000, 1'b0);
      add(0, 55, 0, 2'd0, 24'h0, 24'h000000, 1'b0);
      // mid-frame switch to ramp: bars persist
      add(0, 6, 4, 2'd1, 24'h0, 24'hFFFF00, 1'b0);
      add(0, 0, 8, 2'd1, 24'h0, 24'h000000, 1'b0);
      add(0, 0, 9, 2'd1, 24'h0, 24'h000000, 1'b0);
      add(0, 55, 10, 2'd1, 24'h0, 24'h000000, 1'b0);
      add(0, 0, 11, 2'd1, 24'h0, 24'h000000, 1'b0);
      // frame 1: grey ramp
      add(1, 0, 0, 2'd1, 24'h0, 24'h000000, 1'b1);
      add(1, 1, 0, 2'd1, 24'h0, 24'h010101, 1'b0);
      add(1, 30, 0, 2'd1, 24'h0, 24'h1E1E1E, 1'b0);
      add(1, 47, 2, 2'd1, 24'h0, 24'h2F2F2F, 1'b0);
      add(1, 5, 3, 2'd2, 24'h0, 24'h050505, 1'b0);
      // frame 2: checkerboard, frameCounter = 2
      add(2, 0, 0, 2'd2, 24'h0, 24'h000000, 1'b1);
      add(2, 31, 1, 2'd2, 24'h0, 24'h000000, 1'b0);
      add(2, 32, 1, 2'd2, 24'h0, 24'hFFFFFF, 1'b0);
      add(2, 10, 3, 2'd3, 24'h123456, 24'h000000, 1'b0);
      add(2, 47, 7, 2'd3, 24'h123456, 24'hFFFFFF, 1'b0);
      add(2, 48, 7, 2'd3, 24'h123456, 24'h000000, 1'b0);
      // frame 3: solid, colour change mid-frame waits for frame 4
      add(3, 0, 0, 2'd3, 24'h123456, 24'h123456, 1'b1);
      add(3, 10, 3, 2'd3, 24'hABCDEF, 24'h123456, 1'b0);
      add(3, 48, 3, 2'd3, 24'hABCDEF, 24'h000000, 1'b0);
      add(4, 0, 0, 2'd3, 24'hABCDEF, 24'hABCDEF, 1'b1);

      repeat (3) @(negedge clk);
      check("rst_de", de, 1'b0);
      check("rst_hs", hs, 1'b1);
      check("rst_vs", vs, 1'b1);
      check("rst_rgb", {rC, gC, bC}, 24'h0);
      check("rst_xy", {xC, yC}, 24'h0);
      check("rst_fs", fs, 1'b0);
      check("rstB_sync", {hsB, vsB}, 2'b00);

      resetN = 1'b1;
      cyc = 0;

      foreach (vecs[i]) begin
         patternSelect = vecs[i].pat;
         solidColour = vecs[i].solid;
         target = vecs[i].frame * FR + vecs[i].v * HT + vecs[i].h + 1;
         while (cyc < target) tick();
         check($sformatf("v%0d_rgb", i), {rC, gC, bC}, vecs[i].rgb);
         check($sformatf("v%0d_de", i), de, expDe(vecs[i].h, vecs[i].v));
         check($sformatf("v%0d_hs", i), hs, expHs(vecs[i].h));
         check($sformatf("v%0d_vs", i), vs, expVs(vecs[i].v));
         check($sformatf("v%0d_x", i), xC, 12'(vecs[i].h));
         check($sformatf("v%0d_y", i), yC, 12'(vecs[i].v));
         check($sformatf("v%0d_fs", i), fs, vecs[i].fs);
      end

      // one full frame of timing counts
      while (cyc < 5 * FR) tick();
      deCnt = 0; hsCnt = 0; vsCnt = 0; fsCnt = 0;
      for (int i = 0; i < FR; i++) begin
         tick();
         if (de) deCnt++;
         if (!hs) hsCnt++;
         if (!vs) vsCnt++;
         if (fs) fsCnt++;
      end
      check("frame_de_cycles", deCnt, 384);
      check("frame_hs_cycles", hsCnt, 48);
      check("frame_vs_cycles", vsCnt, 112);
      check("frame_fs_pulses", fsCnt, 1);

      // asynchronous reset mid-frame at (20,5)
      target = 6 * FR + 5 * HT + 20 + 1;
      while (cyc < target) tick();
      check("pre_rst_rgb", {rC, gC, bC}, 24'hABCDEF);
      check("pre_rst_de", de, 1'b1);
      resetN = 1'b0;
      #1;
      check("arst_de", de, 1'b0);
      check("arst_rgb", {rC, gC, bC}, 24'h0);
      check("arst_xy", {xC, yC}, 24'h0);
      check("arst_sync", {hs, vs}, 2'b11);
      check("arst_fs", fs, 1'b0);
      check("arstB_sync", {hsB, vsB}, 2'b00);
      patternSelect = 2'd2;
      solidColour = 24'h0;
      @(negedge clk);
      @(negedge clk);
      resetN = 1'b1;
      cyc = 0;
      tick();
      check("rel_de", de, 1'b1);
      check("rel_fs", fs, 1'b1);
      check("rel_xy", {xC, yC}, 24'h0);
      check("rel_rgb", {rC, gC, bC}, 24'h0);
      check("relB_rgb", {rB, gB, bB}, 24'h0);

      // 64+ frames of checkerboard on A, 256+ frames on B (SYNC_POL=1)
      while (cyc < 64 * FR + 33) begin
         tick();
         p = cyc - 1;
         if (p == 32) check("chkA_f0_x32", {rC, gC, bC}, 24'hFFFFFF);
         if (p == 48) check("relA_de_off", de, 1'b0);
         if (p == 50) check("relA_hs_on", hs, 1'b0);
         if (p == HT) check("relA_line1", {de, xC, yC}, {1'b1, 12'd0, 12'd1});
         if (p == 63 * FR) check("chkA_f63", {rC, gC, bC}, 24'h000000);
         if (p == 64 * FR) begin
            check("chkA_f64", {rC, gC, bC}, 24'hFFFFFF);
            check("chkA_f64_fs", fs, 1'b1);
         end
         if (p == 64 * FR + 32) check("chkA_f64_x32", {rC, gC, bC}, 24'h000000);
         if (p == FRB + 0)  check("B_hs_h0", hsB, 1'b0);
         if (p == FRB + 9)  check("B_hs_h9", hsB, 1'b1);
         if (p == FRB + 11) check("B_hs_h11", hsB, 1'b0);
         if (p == FRB + 36) check("B_vs_v3", vsB, 1'b1);
         if (p == FRB + 48) check("B_vs_v4", vsB, 1'b0);
         if (p % FRB == 0) begin
            f = p / FRB;
            if (f == 127 || f == 255)
               check($sformatf("chkB_f%0d", f), {rB, gB, bB}, 24'hFFFFFF);
            if (f == 128 || f == 256)
               check($sformatf("chkB_f%0d", f), {rB, gB, bB}, 24'h000000);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
